// File: rtl/tone_pkg.sv
// +------------------------------------------------------------------+
// | tone_pkg: shared note codes, default periods and FSM encoding.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package tone_pkg;

    localparam int PERIOD_W = 18;

    localparam logic [2:0] NOTE_DO   = 3'd0;
    localparam logic [2:0] NOTE_RE   = 3'd1;
    localparam logic [2:0] NOTE_MI   = 3'd2;
    localparam logic [2:0] NOTE_FA   = 3'd3;
    localparam logic [2:0] NOTE_SO   = 3'd4;
    localparam logic [2:0] NOTE_LA   = 3'd5;
    localparam logic [2:0] NOTE_XI   = 3'd6;
    localparam logic [2:0] NOTE_NONE = 3'd7;

    localparam logic [PERIOD_W-1:0] DEF_DO      = 18'd190840;
    localparam logic [PERIOD_W-1:0] DEF_RE      = 18'd170068;
    localparam logic [PERIOD_W-1:0] DEF_MI      = 18'd151515;
    localparam logic [PERIOD_W-1:0] DEF_FA      = 18'd143266;
    localparam logic [PERIOD_W-1:0] DEF_SO      = 18'd127551;
    localparam logic [PERIOD_W-1:0] DEF_LA      = 18'd113636;
    localparam logic [PERIOD_W-1:0] DEF_XI      = 18'd101214;
    localparam logic [PERIOD_W-1:0] DEF_TIMEOUT = 18'd262143;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEAS   = 2'd1,
        ST_SILENT = 2'd2
    } state_t;

    // One extra bit so the distance never wraps, whichever side of nominal.
    function automatic logic in_window(
        input logic [PERIOD_W-1:0] p,
        input logic [PERIOD_W-1:0] nom,
        input int unsigned         shift
    );
        logic [PERIOD_W:0] diff;
        logic [PERIOD_W:0] tol;
        if (p >= nom)
            diff = {1'b0, p} - {1'b0, nom};
        else
            diff = {1'b0, nom} - {1'b0, p};
        tol = {1'b0, nom >> shift};
        return diff <= tol;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tone_period_meas.sv
// +------------------------------------------------------------------+
// | tone_period_meas: sync, optional glitch filter, edge detect and  |
// | saturating period counter. Option: TONE_DECODER_GLITCH_FILTER_EN |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tone_period_meas
    import tone_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tone_in,
    output logic                edge_stb,
    output logic [PERIOD_W-1:0] meas_period,
    output logic                timeout
);

    logic                sync1;
    logic                sync2;
    logic                prev;
    logic                level;
    logic                timed_out;
    logic [PERIOD_W-1:0] count;

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    logic [2:0] hist;
    logic       filt;

    // Level only follows sync2 after four consecutive agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b000;
            filt <= 1'b0;
        end else begin
            hist <= {hist[1:0], sync2};
            if (hist == {3{sync2}})
                filt <= sync2;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    assign edge_stb = level & ~prev;
    assign timeout  = (count == TIMEOUT) & ~edge_stb & ~timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            prev        <= 1'b0;
            count       <= '0;
            meas_period <= '0;
            timed_out   <= 1'b0;
        end else begin
            sync1 <= tone_in;
            sync2 <= sync1;
            prev  <= level;
            if (edge_stb) begin
                meas_period <= count;
                count       <= {{(PERIOD_W-1){1'b0}}, 1'b1};
                timed_out   <= 1'b0;
            end else begin
                if (count != {PERIOD_W{1'b1}})
                    count <= count + 1'b1;
                if (timeout)
                    timed_out <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tone_decoder.sv
// +------------------------------------------------------------------+
// | tone_decoder: classifies a square-wave tone period into DO..XI   |
// | with debounce. Option: TONE_DECODER_GLITCH_FILTER_EN             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tone_decoder
    import tone_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] DO         = DEF_DO,
    parameter logic [PERIOD_W-1:0] RE         = DEF_RE,
    parameter logic [PERIOD_W-1:0] MI         = DEF_MI,
    parameter logic [PERIOD_W-1:0] FA         = DEF_FA,
    parameter logic [PERIOD_W-1:0] SO         = DEF_SO,
    parameter logic [PERIOD_W-1:0] LA         = DEF_LA,
    parameter logic [PERIOD_W-1:0] XI         = DEF_XI,
    parameter int unsigned         TOL_SHIFT  = 6,
    parameter logic [PERIOD_W-1:0] TIMEOUT    = DEF_TIMEOUT,
    parameter logic [2:0]          STABLE_CNT = 3'd3
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tone_in,
    output logic [2:0]          note,
    output logic                note_valid,
    output logic                note_chg,
    output logic [PERIOD_W-1:0] period
);

    localparam logic [6:0][PERIOD_W-1:0] NOMS = {XI, LA, SO, FA, MI, RE, DO};

    logic                edge_stb;
    logic                timeout;
    logic [PERIOD_W-1:0] meas_period;
    state_t              state;
    logic                pend;
    logic [2:0]          cls;
    logic [2:0]          last_cls;
    logic [2:0]          stab_cnt;
    logic [2:0]          stab_next;

    tone_period_meas #(
        .TIMEOUT (TIMEOUT)
    ) u_meas (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .tone_in     (tone_in),
        .edge_stb    (edge_stb),
        .meas_period (meas_period),
        .timeout     (timeout)
    );

    // Scan high to low so the lowest matching index is the one kept.
    always_comb begin
        cls = NOTE_NONE;
        for (int k = 6; k >= 0; k--) begin
            if (in_window(meas_period, NOMS[k], TOL_SHIFT))
                cls = 3'(k);
        end
    end

    always_comb begin
        stab_next = 3'd1;
        if (cls == last_cls)
            stab_next = (stab_cnt >= STABLE_CNT) ? STABLE_CNT : stab_cnt + 3'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            pend       <= 1'b0;
            last_cls   <= NOTE_NONE;
            stab_cnt   <= 3'd0;
            note       <= NOTE_DO;
            note_valid <= 1'b0;
            note_chg   <= 1'b0;
            period     <= '0;
        end else begin
            note_chg <= 1'b0;
            pend     <= 1'b0;

            // meas_period was latched on the previous cycle's edge.
            if (pend) begin
                period   <= meas_period;
                last_cls <= cls;
                stab_cnt <= stab_next;
                if (stab_next == STABLE_CNT) begin
                    if (cls != NOTE_NONE) begin
                        if ((cls != note) || !note_valid) begin
                            note       <= cls;
                            note_valid <= 1'b1;
                            note_chg   <= 1'b1;
                        end
                    end else if (note_valid) begin
                        note_valid <= 1'b0;
                        note_chg   <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (edge_stb)
                        state <= ST_MEAS;
                end
                ST_MEAS: begin
                    if (edge_stb) begin
                        pend <= 1'b1;
                    end else if (timeout) begin
                        state    <= ST_SILENT;
                        stab_cnt <= 3'd0;
                        if (note_valid) begin
                            note_valid <= 1'b0;
                            note_chg   <= 1'b1;
                        end
                    end
                end
                ST_SILENT: begin
                    if (edge_stb)
                        state <= ST_MEAS;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tone_decoder.sv
// +------------------------------------------------------------------+
// | tb_tone_decoder: scoreboard bench for tone_decoder with scaled   |
// | periods. Option: TONE_DECODER_GLITCH_FILTER_EN                   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_tone_decoder;

    localparam int P_DO = 1908;
    localparam int P_RE = 1700;
    localparam int P_MI = 1515;
    localparam int P_FA = 1432;
    localparam int P_SO = 1275;
    localparam int P_LA = 1136;
    localparam int P_XI = 1012;
    localparam int P_GAP = 1600;
    localparam int TO   = 4000;
`ifdef TONE_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [2:0] note;
        logic       valid;
        int         cyc;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        tone_in;
    logic [2:0]  note;
    logic        note_valid;
    logic        note_chg;
    logic [17:0] period;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   chg_count = 0;
    int   cyc = 0;
    int   last_rise = 0;

    tone_decoder #(
        .DO         (18'(P_DO)),
        .RE         (18'(P_RE)),
        .MI         (18'(P_MI)),
        .FA         (18'(P_FA)),
        .SO         (18'(P_SO)),
        .LA         (18'(P_LA)),
        .XI         (18'(P_XI)),
        .TOL_SHIFT  (6),
        .TIMEOUT    (18'(TO)),
        .STABLE_CNT (3'd3)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tone_in    (tone_in),
        .note       (note),
        .note_valid (note_valid),
        .note_chg   (note_chg),
        .period     (period)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Every note_chg pulse consumes exactly one expected entry.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (note_chg === 1'b1) begin
            chg_count = chg_count + 1;
            n_checks  = n_checks + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_chg: got note=%0d valid=%0d at cycle %0d, expected no pulse",
                         note, note_valid, cyc);
            end else begin
                e = exp_q.pop_front();
                if (note !== e.note || note_valid !== e.valid || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL chg_event: got note=%0d valid=%0d cycle=%0d, expected note=%0d valid=%0d cycle=%0d",
                             note, note_valid, cyc, e.note, e.valid, e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [2:0] n, input logic v, input int c);
        exp_t e;
        e.note  = n;
        e.valid = v;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic tone(input int p);
        tone_in   = 1'b1;
        last_rise = cyc;
        repeat (p / 2) @(negedge sys_clk);
        tone_in = 1'b0;
        repeat (p - p / 2) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        tone_in   = 1'b0;
        repeat (5) @(negedge sys_clk);
        n_checks = n_checks + 1;
        if ({note, note_valid, note_chg, period} !== 23'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_values: got note=%0d valid=%0d chg=%0d period=%0d, expected all 0",
                     note, note_valid, note_chg, period);
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic test_do_lock;
        push_exp(3'd0, 1'b1, -1);
        repeat (5) tone(P_DO);
        n_checks = n_checks + 1;
        if (exp_q.size() !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL do_lock_chg: %0d pending note_chg events, expected 0", exp_q.size());
        end
        n_checks = n_checks + 1;
        if (note !== 3'd0 || note_valid !== 1'b1 || period !== 18'(P_DO)) begin
            n_fail = n_fail + 1;
            $display("FAIL do_lock_out: got note=%0d valid=%0d period=%0d, expected 0 1 %0d",
                     note, note_valid, period, P_DO);
        end
    endtask

    task automatic test_do_to_mi;
        int c0;
        c0 = chg_count;
        repeat (3) tone(P_MI);
        n_checks = n_checks + 1;
        if (note !== 3'd0 || note_valid !== 1'b1 || chg_count != c0) begin
            n_fail = n_fail + 1;
            $display("FAIL mi_hold: got note=%0d valid=%0d chgs=%0d, expected 0 1 0",
                     note, note_valid, chg_count - c0);
        end
        push_exp(3'd2, 1'b1, -1);
        tone(P_MI);
        n_checks = n_checks + 1;
        if (note !== 3'd2 || period !== 18'(P_MI) || chg_count != c0 + 1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL mi_switch: got note=%0d period=%0d chgs=%0d, expected 2 %0d 1",
                     note, period, chg_count - c0, P_MI);
        end
    endtask

    task automatic test_la_jitter;
        int c0;
        int p;
        int p_prev;
        c0 = chg_count;
        p_prev = 0;
        push_exp(3'd5, 1'b1, -1);
        for (int i = 0; i < 8; i++) begin
            p = P_LA + int'($urandom_range(30)) - 15;
            p_prev = (i == 7) ? p_prev : p;
            tone(p);
        end
        n_checks = n_checks + 1;
        if (note !== 3'd5 || note_valid !== 1'b1 || chg_count != c0 + 1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL la_jitter: got note=%0d valid=%0d chgs=%0d, expected 5 1 1",
                     note, note_valid, chg_count - c0);
        end
        n_checks = n_checks + 1;
        if (period !== 18'(p_prev)) begin
            n_fail = n_fail + 1;
            $display("FAIL la_period: got %0d, expected %0d", period, p_prev);
        end
    endtask

    task automatic test_none;
        int c0;
        c0 = chg_count;
        push_exp(3'd5, 1'b0, -1);
        repeat (4) tone(P_GAP);
        n_checks = n_checks + 1;
        if (note_valid !== 1'b0 || note !== 3'd5 || period !== 18'(P_GAP)
            || chg_count != c0 + 1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL none_class: got valid=%0d note=%0d period=%0d chgs=%0d, expected 0 5 %0d 1",
                     note_valid, note, period, chg_count - c0, P_GAP);
        end
    endtask

    task automatic test_silence;
        int c0;
        push_exp(3'd6, 1'b1, -1);
        repeat (4) tone(P_XI);
        n_checks = n_checks + 1;
        if (note !== 3'd6 || note_valid !== 1'b1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL xi_lock: got note=%0d valid=%0d pending=%0d, expected 6 1 0",
                     note, note_valid, exp_q.size());
        end
        push_exp(3'd6, 1'b0, last_rise + LAT + TO);
        while (cyc < last_rise + LAT + TO + 20) @(negedge sys_clk);
        n_checks = n_checks + 1;
        if (exp_q.size() != 0 || note_valid !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL timeout: got valid=%0d pending=%0d, expected 0 0", note_valid, exp_q.size());
        end
        c0 = chg_count;
        tone(P_XI);
        n_checks = n_checks + 1;
        if (note_valid !== 1'b0 || chg_count != c0) begin
            n_fail = n_fail + 1;
            $display("FAIL silent_edge: got valid=%0d chgs=%0d, expected 0 0", note_valid, chg_count - c0);
        end
    endtask

    task automatic test_async_reset;
        int c0;
        push_exp(3'd6, 1'b1, -1);
        repeat (3) tone(P_XI);
        n_checks = n_checks + 1;
        if (note_valid !== 1'b1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL relock: got valid=%0d pending=%0d, expected 1 0", note_valid, exp_q.size());
        end
        tone_in = 1'b1;
        repeat (P_XI / 2) @(negedge sys_clk);
        tone_in = 1'b0;
        repeat (100) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if ({note, note_valid, note_chg, period} !== 23'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL async_reset: got note=%0d valid=%0d chg=%0d period=%0d, expected all 0",
                     note, note_valid, note_chg, period);
        end
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        c0 = chg_count;
        repeat (3) tone(P_XI);
        n_checks = n_checks + 1;
        if (note_valid !== 1'b0 || chg_count != c0) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_early: got valid=%0d chgs=%0d, expected 0 0", note_valid, chg_count - c0);
        end
        push_exp(3'd6, 1'b1, -1);
        tone(P_XI);
        n_checks = n_checks + 1;
        if (note !== 3'd6 || note_valid !== 1'b1 || exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_lock: got note=%0d valid=%0d pending=%0d, expected 6 1 0",
                     note, note_valid, exp_q.size());
        end
    endtask

`ifdef TONE_DECODER_GLITCH_FILTER_EN
    task automatic spiky_tone(input int p);
        int h;
        int l;
        h = p / 2;
        l = p - h;
        tone_in   = 1'b1;
        last_rise = cyc;
        repeat (h / 3) @(negedge sys_clk);
        tone_in = 1'b0;
        repeat (2) @(negedge sys_clk);
        tone_in = 1'b1;
        repeat (h - h / 3 - 2) @(negedge sys_clk);
        tone_in = 1'b0;
        repeat (l / 3) @(negedge sys_clk);
        tone_in = 1'b1;
        repeat (2) @(negedge sys_clk);
        tone_in = 1'b0;
        repeat (l - l / 3 - 2) @(negedge sys_clk);
    endtask

    task automatic test_glitch;
        int c0;
        c0 = chg_count;
        repeat (4) spiky_tone(P_XI);
        n_checks = n_checks + 1;
        if (period !== 18'(P_XI) || note !== 3'd6 || note_valid !== 1'b1 || chg_count != c0) begin
            n_fail = n_fail + 1;
            $display("FAIL glitch_filter: got period=%0d note=%0d valid=%0d chgs=%0d, expected %0d 6 1 0",
                     period, note, note_valid, chg_count - c0, P_XI);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_do_lock();
        test_do_to_mi();
        test_la_jitter();
        test_none();
        test_silence();
        test_async_reset();
`ifdef TONE_DECODER_GLITCH_FILTER_EN
        test_glitch();
`endif
        repeat (10) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the note-sequencing buzzer driver.
- Takes a square-wave tone input (buzzer drive line or external mic comparator), measures its period in sys_clk cycles, and classifies it as one of seven scale notes (DO..XI) or "no tone".
- Publishes a debounced note code for LEDs, a score checker, or a self-test loopback of the tone generator.

Parameters:
- DO, 18'd190840: nominal DO period in clocks (generator count + 1)
- RE, 18'd170068: nominal RE period
- MI, 18'd151515: nominal MI period
- FA, 18'd143266: nominal FA period
- SO, 18'd127551: nominal SO period
- LA, 18'd113636: nominal LA period
- XI, 18'd101214: nominal XI period
- TOL_SHIFT, 6: match window is nominal ± (nominal >> TOL_SHIFT), about ±1.56%
- TIMEOUT, 18'd262143: clocks without a rising edge before silence is declared
- STABLE_CNT, 3'd3: consecutive identical classifications required before note updates (1..7)

Ports:
- sys_clk, input, 1: system clock, 50 MHz
- sys_rst_n, input, 1: asynchronous active-low reset
- tone_in, input, 1: asynchronous square-wave tone
- note, output, 3: current note, 0=DO .. 6=XI
- note_valid, output, 1: high while a stable note is detected
- note_chg, output, 1: one-cycle pulse whenever note or note_valid changes
- period, output, 18: last measured period in clocks (saturating)

Behaviour:
- Reset values:
  - note=0, note_valid=0, note_chg=0, period=0.
  - Internal: sync flops 0, period counter 0, stability counter 0, state IDLE.
- Input path:
  - 2-flop synchroniser, then a registered previous sample.
  - A rising edge is sync2 & ~prev.
  - Edge strobe asserts 3 clocks after a tone_in rise.
- Period counter, 18 bits:
  - Increments every clock and saturates at 2^18-1.
  - Cleared to 1 on an edge strobe, so the value seen at the next edge equals the period.
- FSM states:
  - IDLE: waiting for the first edge. On edge → MEAS. No classification, because the first edge has no reference.
  - MEAS: counting.
    - On edge: latch count into period, classify, → MEAS.
    - When count reaches TIMEOUT with no edge → SILENT.
  - SILENT: on entry, if note_valid=1 then clear note_valid and pulse note_chg; clear the stability counter. On edge → MEAS.
- Classification:
  - Combinational, registered one cycle after the edge.
  - Match k when |period - P_k| <= P_k >> TOL_SHIFT, computed in 19-bit unsigned arithmetic with no wrap.
  - If several notes match, the lowest index wins.
  - No match gives class 7 (NONE).
- Stability:
  - If class equals the previous class, the stability counter increments, saturating at STABLE_CNT; otherwise it loads 1.
  - When the counter reaches STABLE_CNT with class != 7 and (class != note or note_valid==0): update note, set note_valid=1, and pulse note_chg in the same cycle.
  - STABLE_CNT reached with class 7: clear note_valid, pulse note_chg if it was set.
- Edge vs timeout in the same cycle: the edge wins and timeout is not entered.
- Tone change mid-note: the old note is held until the new class is stable. Pure period jitter inside the window causes no note_chg.
- Reset asserted mid-measurement: all state returns to reset values immediately (async). The first post-reset edge is only a reference.

Optional Feature:
- Macro TONE_DECODER_GLITCH_FILTER_EN.
- Defined:
  - A 4-cycle glitch filter follows the synchroniser. The filtered level changes only after 4 consecutive equal samples.
  - Pulses and gaps of 3 clocks or fewer are ignored.
  - Edge strobe latency grows from 3 to 7 clocks. Measured periods are unchanged for clean inputs.
- Undefined: no filter; latency is 3 clocks.

Decomposition:
- Package tone_pkg:
  - Note code constants NOTE_DO..NOTE_XI, NOTE_NONE=3'd7.
  - Default period constants.
  - 18-bit period width constant.
  - FSM state encoding (IDLE, MEAS, SILENT).
- One sub-module: tone_period_meas, which contains the synchroniser, optional filter, edge detect, saturating period counter and timeout flag. It outputs an edge strobe, the latched period and a timeout pulse.
- Classifier and stability logic stay in tone_decoder.

Test Plan:
- DO period 190840 for 5 periods → note_chg pulse and note=0, note_valid=1 after the 4th rising edge (3 classifications). period=190840.
- Switch from DO to MI (151515) → note stays 0 for 2 MI periods. On the 3rd MI classification: note=2, single note_chg.
- LA period jittering 113636±1500 → note=5 stable, no extra note_chg.
- Period 160000 (between RE and MI windows) for 3 periods → class NONE, note_valid drops, one note_chg.
- Input held low after XI → note_valid=0 and note_chg exactly TIMEOUT clocks after the last counter clear. A following edge alone does not revalidate.
- Assert sys_rst_n mid-period, then release → all outputs 0 immediately. The next valid note needs 1 + STABLE_CNT edges. With TONE_DECODER_GLITCH_FILTER_EN, injected 2-clock spikes leave period unchanged.
